// File: rtl/pmem_burst_responder.sv
// -----------------------------------------------------------------------------
// pmem_burst_responder
//
// Behavioural physical-memory model that answers 32-byte line reads and writes
// as four 64-bit beats after a fixed latency.
//
// Parameters
//   LATENCY  cycles from the request-accept edge to the first response beat
//            (1..15)
//   LINES    backing-store depth in 32-byte lines (power of 2, 2..1024)
//
// Ports
//   clk           single clock, rising edge
//   rst           asynchronous active-low reset
//   mem_read      line-read request, held by the initiator until the final beat
//   mem_write     line-write request, held by the initiator until the final beat
//   mem_addr      line address, bits [4:0] ignored, upper bits alias
//   mem_wdata     write beat, advanced by the initiator after each strobed beat
//   mem_rdata     read beat, valid while mem_resp is high, otherwise zero
//   mem_resp      beat strobe, four consecutive cycles per completed burst
//   busy          high whenever the responder is not idle
//   protocol_err  one-cycle pulse on an illegal request pattern or an abort
// -----------------------------------------------------------------------------
module pmem_burst_responder #(
    parameter int unsigned LATENCY = 3,
    parameter int unsigned LINES   = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [63:0] mem_wdata,
    output logic [63:0] mem_rdata,
    output logic        mem_resp,
    output logic        busy,
    output logic        protocol_err
);

    localparam int unsigned IDX_W     = $clog2(LINES);
    localparam logic [3:0]  WAIT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic [3:0]         wait_cnt_q;
    logic [1:0]         beat_q;
    logic               op_wr_q;
    logic [IDX_W-1:0]   idx_q;
    logic               mem_resp_q;
    logic               busy_q;
    logic               perr_q;

    // Storage: one 64-bit word per beat, addressed as {line, beat}.
    logic [63:0]        mem_q [LINES*4];

    logic               req_held_s;
    logic               wr_en_s;
    logic [IDX_W+1:0]   word_addr_s;
    logic [63:0]        rdata_s;

    // Address bits outside the line index are intentionally ignored.
    logic               unused_addr_s;
    assign unused_addr_s = ^{mem_addr[31:5+IDX_W], mem_addr[4:0]};

    // Request line that must stay high for the transaction in flight.
    always_comb begin
        req_held_s = 1'b0;
        if (op_wr_q) begin
            req_held_s = mem_write;
        end else begin
            req_held_s = mem_read;
        end
    end

    // Write strobe: only while a write beat is presented and still requested,
    // so a dropped request or reset stops any further storage update.
    always_comb begin
        word_addr_s = {idx_q, beat_q};
        wr_en_s     = 1'b0;
        if ((state_q == ST_BURST) && op_wr_q && mem_write) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Read data is combinational from the latched line and beat counter.
    always_comb begin
        rdata_s = 64'h0;
        if (mem_resp_q && !op_wr_q) begin
            rdata_s = mem_q[word_addr_s];
        end else begin
            rdata_s = 64'h0;
        end
    end

    // Transaction FSM with its counters, latched request and registered strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            beat_q     <= 2'd0;
            op_wr_q    <= 1'b0;
            idx_q      <= '0;
            mem_resp_q <= 1'b0;
            busy_q     <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            perr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (mem_read && mem_write) begin
                        // Conflicting request: refuse it without touching state.
                        perr_q <= 1'b1;
                    end else if (mem_read || mem_write) begin
                        op_wr_q    <= mem_write;
                        idx_q      <= mem_addr[5 +: IDX_W];
                        wait_cnt_q <= WAIT_LOAD;
                        busy_q     <= 1'b1;
                        state_q    <= ST_WAIT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (!req_held_s) begin
                        state_q    <= ST_IDLE;
                        wait_cnt_q <= 4'd0;
                        busy_q     <= 1'b0;
                        perr_q     <= 1'b1;
                    end else if (wait_cnt_q == 4'd0) begin
                        beat_q     <= 2'd0;
                        mem_resp_q <= 1'b1;
                        state_q    <= ST_BURST;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 4'd1;
                    end
                end
                ST_BURST: begin
                    if (!req_held_s) begin
                        // Abort: beats already written stay in storage.
                        state_q    <= ST_IDLE;
                        beat_q     <= 2'd0;
                        mem_resp_q <= 1'b0;
                        busy_q     <= 1'b0;
                        perr_q     <= 1'b1;
                    end else if (beat_q == 2'd3) begin
                        beat_q     <= 2'd0;
                        mem_resp_q <= 1'b0;
                        state_q    <= ST_DONE;
                    end else begin
                        beat_q <= beat_q + 2'd1;
                    end
                end
                ST_DONE: begin
                    // Request is deliberately not sampled here.
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    wait_cnt_q <= 4'd0;
                    beat_q     <= 2'd0;
                    mem_resp_q <= 1'b0;
                    busy_q     <= 1'b0;
                    perr_q     <= 1'b0;
                end
            endcase
        end
    end

    // Backing store write port; intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[word_addr_s] <= mem_wdata;
        end
    end

    assign mem_rdata    = rdata_s;
    assign mem_resp     = mem_resp_q;
    assign busy         = busy_q;
    assign protocol_err = perr_q;

endmodule

// File: tb/tb_pmem_burst_responder.sv
// -----------------------------------------------------------------------------
// Directed testbench for pmem_burst_responder. Three instances with LATENCY
// 3, 1 and 15 share clock and reset; the LATENCY=3 instance carries the data
// tests, the other two only the response timing.
// -----------------------------------------------------------------------------
module tb_pmem_burst_responder;

    logic        clk;
    logic        rst;
    logic        rd, wr, rd1, rd15, wr_off;
    logic [31:0] addr;
    logic [63:0] wdata;

    logic [63:0] rdata3, rdata1, rdata15;
    logic        resp3, resp1, resp15;
    logic        busy3, busy1, busy15;
    logic        perr3, perr1, perr15;

    int checks = 0;
    int errors = 0;

    pmem_burst_responder #(.LATENCY(3), .LINES(64)) u3 (
        .clk(clk), .rst(rst), .mem_read(rd), .mem_write(wr), .mem_addr(addr),
        .mem_wdata(wdata), .mem_rdata(rdata3), .mem_resp(resp3), .busy(busy3),
        .protocol_err(perr3)
    );

    pmem_burst_responder #(.LATENCY(1), .LINES(64)) u1 (
        .clk(clk), .rst(rst), .mem_read(rd1), .mem_write(wr_off), .mem_addr(addr),
        .mem_wdata(wdata), .mem_rdata(rdata1), .mem_resp(resp1), .busy(busy1),
        .protocol_err(perr1)
    );

    pmem_burst_responder #(.LATENCY(15), .LINES(64)) u15 (
        .clk(clk), .rst(rst), .mem_read(rd15), .mem_write(wr_off), .mem_addr(addr),
        .mem_wdata(wdata), .mem_rdata(rdata15), .mem_resp(resp15), .busy(busy15),
        .protocol_err(perr15)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete LATENCY=3 burst on u3. For reads d0..d3 are the expected
    // beats, for writes the data driven. The address is switched to a_after
    // right after the accept edge.
    task automatic burst3(input string tag, input logic is_wr, input logic [31:0] a,
                          input logic [31:0] a_after, input logic [63:0] d0,
                          input logic [63:0] d1, input logic [63:0] d2,
                          input logic [63:0] d3);
        logic [63:0] d [4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        rd = ~is_wr; wr = is_wr; addr = a; wdata = d0;
        tick();
        chk({tag, "_busy_accept"}, 64'(busy3), 64'd1);
        chk({tag, "_resp_accept"}, 64'(resp3), 64'd0);
        addr = a_after;
        for (int w = 0; w < 2; w++) begin
            tick();
            chk($sformatf("%s_resp_wait%0d", tag, w), 64'(resp3), 64'd0);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("%s_resp_beat%0d", tag, k), 64'(resp3), 64'd1);
            if (!is_wr) chk($sformatf("%s_rdata_beat%0d", tag, k), rdata3, d[k]);
            wdata = d[k];
        end
        tick();
        chk({tag, "_resp_done"}, 64'(resp3), 64'd0);
        chk({tag, "_busy_done"}, 64'(busy3), 64'd1);
        chk({tag, "_rdata_done"}, rdata3, 64'd0);
        rd = 1'b0; wr = 1'b0;
        tick();
        chk({tag, "_busy_idle"}, 64'(busy3), 64'd0);
        chk({tag, "_perr_idle"}, 64'(perr3), 64'd0);
    endtask

    initial begin
        rst = 1'b1; rd = 1'b0; wr = 1'b0; rd1 = 1'b0; rd15 = 1'b0; wr_off = 1'b0;
        addr = 32'h0; wdata = 64'h0;

        // Reset state
        #2 rst = 1'b0;
        #1;
        chk("rst_resp", 64'(resp3), 64'd0);
        chk("rst_busy", 64'(busy3), 64'd0);
        chk("rst_perr", 64'(perr3), 64'd0);
        chk("rst_rdata", rdata3, 64'd0);
        tick(); tick();
        rst = 1'b1;
        tick();

        // Write line 0x40 then read it back
        burst3("wr40", 1'b1, 32'h40, 32'h40, {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}});
        burst3("rd40", 1'b0, 32'h40, 32'h40, {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}});

        // Prefill line 0x80, then check address changes after accept are ignored
        burst3("wr80", 1'b1, 32'h80, 32'h80, 64'hC0C0_0000_0000_0000, 64'hC1C1_0000_0000_0001,
               64'hC2C2_0000_0000_0002, 64'hC3C3_0000_0000_0003);
        burst3("rd40_addrchg", 1'b0, 32'h40, 32'h80, {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}});
        // Upper address bits alias onto the same line
        burst3("rd80_alias", 1'b0, 32'h0001_0080, 32'h0, 64'hC0C0_0000_0000_0000,
               64'hC1C1_0000_0000_0001, 64'hC2C2_0000_0000_0002, 64'hC3C3_0000_0000_0003);

        // Write to 0x80 aborted after two beats
        wr = 1'b1; addr = 32'h80; wdata = {16{4'hA}};
        tick(); tick(); tick(); tick();
        chk("abort_resp_beat0", 64'(resp3), 64'd1);
        tick();
        wdata = {16{4'hB}};
        chk("abort_resp_beat1", 64'(resp3), 64'd1);
        tick();
        chk("abort_resp_beat2", 64'(resp3), 64'd1);
        wr = 1'b0;
        tick();
        chk("abort_resp", 64'(resp3), 64'd0);
        chk("abort_perr", 64'(perr3), 64'd1);
        chk("abort_busy", 64'(busy3), 64'd0);
        tick();
        chk("abort_perr_end", 64'(perr3), 64'd0);
        burst3("rd80_after_abort", 1'b0, 32'h80, 32'h80, {16{4'hA}}, {16{4'hB}},
               64'hC2C2_0000_0000_0002, 64'hC3C3_0000_0000_0003);

        // Both requests high in IDLE
        rd = 1'b1; wr = 1'b1; addr = 32'h40;
        tick();
        chk("both_perr", 64'(perr3), 64'd1);
        chk("both_busy", 64'(busy3), 64'd0);
        chk("both_resp", 64'(resp3), 64'd0);
        rd = 1'b0; wr = 1'b0;
        tick();
        chk("both_perr_end", 64'(perr3), 64'd0);
        chk("both_busy_end", 64'(busy3), 64'd0);
        chk("both_resp_end", 64'(resp3), 64'd0);
        burst3("rd40_after_both", 1'b0, 32'h40, 32'h40, {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}});

        // Reset during beat 1 of a write
        burst3("wrC0", 1'b1, 32'hC0, 32'hC0, 64'hE0, 64'hE1, 64'hE2, 64'hE3);
        wr = 1'b1; addr = 32'hC0; wdata = {16{4'h5}};
        tick(); tick(); tick(); tick();
        chk("rstmid_resp_beat0", 64'(resp3), 64'd1);
        tick();
        wdata = {16{4'h6}};
        chk("rstmid_resp_beat1", 64'(resp3), 64'd1);
        #2 rst = 1'b0;
        #1;
        chk("rstmid_resp", 64'(resp3), 64'd0);
        chk("rstmid_busy", 64'(busy3), 64'd0);
        chk("rstmid_perr", 64'(perr3), 64'd0);
        chk("rstmid_rdata", rdata3, 64'd0);
        tick(); tick();
        chk("rstmid_resp_held", 64'(resp3), 64'd0);
        wr = 1'b0;
        rst = 1'b1;
        tick();
        chk("rstmid_busy_after", 64'(busy3), 64'd0);
        burst3("rdC0_after_rst", 1'b0, 32'hC0, 32'hC0, {16{4'h5}}, 64'hE1, 64'hE2, 64'hE3);

        // LATENCY=1: first beat one cycle after accept
        rd1 = 1'b1; addr = 32'h40;
        tick();
        chk("l1_busy_accept", 64'(busy1), 64'd1);
        chk("l1_resp_accept", 64'(resp1), 64'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("l1_resp_beat%0d", k), 64'(resp1), 64'd1);
            chk($sformatf("l1_busy_beat%0d", k), 64'(busy1), 64'd1);
        end
        tick();
        chk("l1_resp_done", 64'(resp1), 64'd0);
        chk("l1_busy_done", 64'(busy1), 64'd1);
        chk("l1_rdata_done", rdata1, 64'd0);
        rd1 = 1'b0;
        tick();
        chk("l1_busy_idle", 64'(busy1), 64'd0);

        // LATENCY=15: first beat fifteen cycles after accept
        rd15 = 1'b1;
        tick();
        chk("l15_busy_accept", 64'(busy15), 64'd1);
        chk("l15_resp_accept", 64'(resp15), 64'd0);
        for (int w = 1; w < 15; w++) begin
            tick();
            chk($sformatf("l15_resp_wait%0d", w), 64'(resp15), 64'd0);
            chk($sformatf("l15_busy_wait%0d", w), 64'(busy15), 64'd1);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("l15_resp_beat%0d", k), 64'(resp15), 64'd1);
        end
        tick();
        chk("l15_resp_done", 64'(resp15), 64'd0);
        chk("l15_busy_done", 64'(busy15), 64'd1);
        chk("l15_rdata_done", rdata15, 64'd0);
        chk("l15_perr_done", 64'(perr15), 64'd0);
        rd15 = 1'b0;
        tick();
        chk("l15_busy_idle", 64'(busy15), 64'd0);
        chk("l1_perr_end", 64'(perr1), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
